uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_param.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with a 2-flop input synchronizer and a
// first-word-fall-through receive FIFO carrying per-entry error flags.
module uart_rx_param #(
    parameter int unsigned CLK_HZ       = 100000000,
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned CLKS_PER_BIT = CLK_HZ / BIT_RATE,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               uart_rxd,
    output logic [DATA_BITS-1:0]               uart_rx_data,
    output logic                               uart_parity_err,
    output logic                               uart_frame_err,
    output logic                               uart_valid,
    input  logic                               uart_ready,
    output logic                               uart_overrun,
    output logic                               uart_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ENT_W  = DATA_BITS + 2;
    localparam int unsigned BIT_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_HIGH
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_sync1;
    logic                   r_sync2;
    logic [CNT_W-1:0]       r_cnt;
    logic [BIT_W-1:0]       r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   r_push;
    logic                   w_rxd_s;
    logic                   w_mid;
    logic                   w_tick;
    logic                   w_last_data;
    logic                   w_last_stop;
    logic                   w_par;

    logic [ENT_W-1:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [FCNT_W-1:0]      r_count;
    logic                   r_overrun;
    logic                   w_valid;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_wr;
    logic [ENT_W-1:0]       w_head;

    // Synchronizer resets to the idle-high level so reset release is not a start edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rxd;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxd_s     = r_sync2;
    assign w_mid       = (r_cnt == CNT_W'(CLKS_PER_BIT / 2));
    assign w_tick      = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign w_last_data = (r_bit_idx == BIT_W'(DATA_BITS - 1));
    assign w_last_stop = (r_bit_idx == BIT_W'(STOP_BITS - 1));
    assign w_par       = (^r_shift) ^ w_rxd_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:      if (!w_rxd_s) w_next = ST_START;
            ST_START:     if (w_mid) w_next = w_rxd_s ? ST_IDLE : ST_DATA;
            ST_DATA:      if (w_tick && w_last_data) w_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY:    if (w_tick) w_next = ST_STOP;
            ST_STOP: begin
                if (w_tick) begin
                    if (!w_rxd_s)         w_next = ST_WAIT_HIGH;
                    else if (w_last_stop) w_next = ST_IDLE;
                end
            end
            ST_WAIT_HIGH: if (w_rxd_s) w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        uart_busy = (r_state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_push    <= 1'b0;
        end else begin
            r_push <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                    r_perr    <= 1'b0;
                    r_ferr    <= 1'b0;
                end
                ST_START: r_cnt <= w_mid ? '0 : r_cnt + CNT_W'(1);
                ST_DATA: begin
                    if (w_tick) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= w_last_data ? '0 : r_bit_idx + BIT_W'(1);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        r_cnt  <= '0;
                        r_perr <= (PARITY == 1) ? ~w_par : w_par;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        if (!w_rxd_s) begin
                            r_ferr <= 1'b1;
                            r_push <= 1'b1;
                        end else if (w_last_stop) begin
                            r_push <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + BIT_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == FCNT_W'(FIFO_DEPTH));
    assign w_pop   = w_valid && uart_ready;
    // A full FIFO still accepts the push when the head leaves in the same cycle
    assign w_wr    = r_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= {r_shift, r_perr, r_ferr};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= r_push && w_full && !w_pop;
            if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            unique case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + FCNT_W'(1);
                2'b01:   r_count <= r_count - FCNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head          = r_mem[r_rd_ptr];
    assign uart_valid      = w_valid;
    assign uart_rx_data    = w_valid ? w_head[ENT_W-1:2] : '0;
    assign uart_parity_err = w_valid ? w_head[1] : 1'b0;
    assign uart_frame_err  = w_valid ? w_head[0] : 1'b0;
    assign uart_overrun    = r_overrun;
    assign fifo_count      = r_count;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and an 8E1 instance,
// both at 16 clocks per bit with a 4-entry FIFO.
module tb_uart_rx_param;

    localparam int unsigned CPB = 16;

    logic       clk;
    logic       reset;
    logic       rxd_a, rxd_b;
    logic       ready_a, ready_b;
    logic [7:0] data_a, data_b;
    logic       perr_a, perr_b;
    logic       ferr_a, ferr_b;
    logic       valid_a, valid_b;
    logic       ovr_a, ovr_b;
    logic       busy_a, busy_b;
    logic [2:0] cnt_a, cnt_b;

    int n_checks = 0;
    int n_fail   = 0;
    int ov_cnt   = 0;
    int ov0;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .reset(reset), .uart_rxd(rxd_a), .uart_rx_data(data_a),
        .uart_parity_err(perr_a), .uart_frame_err(ferr_a), .uart_valid(valid_a),
        .uart_ready(ready_a), .uart_overrun(ovr_a), .uart_busy(busy_a), .fifo_count(cnt_a)
    );

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .reset(reset), .uart_rxd(rxd_b), .uart_rx_data(data_b),
        .uart_parity_err(perr_b), .uart_frame_err(ferr_b), .uart_valid(valid_b),
        .uart_ready(ready_b), .uart_overrun(ovr_b), .uart_busy(busy_b), .fifo_count(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (ovr_a) ov_cnt <= ov_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input int t, input logic b);
        if (t == 0) rxd_a = b;
        else        rxd_b = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input int t, input logic [7:0] d, input bit use_par, input bit pbit);
        drive_bit(t, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(t, d[i]);
        if (use_par) drive_bit(t, pbit);
        drive_bit(t, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_a();
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
    endtask

    task automatic pop_b();
        ready_b = 1'b1;
        @(negedge clk);
        ready_b = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        rxd_a = 1'b1;  rxd_b = 1'b1;
        ready_a = 1'b0; ready_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", data_a, 8'h00);
        check("rst_valid", valid_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_ovr", ovr_a, 1'b0);
        check("rst_count", cnt_a, 3'd0);
        check("rst_errs", {perr_a, ferr_a}, 2'b00);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy", busy_a, 1'b0);

        send_frame(0, 8'hA5, 1'b0, 1'b0);
        check("a5_valid", valid_a, 1'b1);
        check("a5_data", data_a, 8'hA5);
        check("a5_errs", {perr_a, ferr_a}, 2'b00);
        check("a5_count", cnt_a, 3'd1);
        pop_a();
        check("a5_pop_count", cnt_a, 3'd0);
        check("a5_pop_valid", valid_a, 1'b0);

        send_frame(1, 8'h03, 1'b1, 1'b1);
        check("par_data", data_b, 8'h03);
        check("par_perr", perr_b, 1'b1);
        check("par_ferr", ferr_b, 1'b0);
        pop_b();
        send_frame(1, 8'h03, 1'b1, 1'b0);
        check("par_ok_perr", perr_b, 1'b0);
        check("par_ok_valid", valid_b, 1'b1);
        pop_b();
        check("par_count", cnt_b, 3'd0);

        rxd_a = 1'b0;
        repeat (4) @(negedge clk);
        rxd_a = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_busy_hi", busy_a, 1'b1);
        repeat (20) @(negedge clk);
        check("glitch_busy_lo", busy_a, 1'b0);
        check("glitch_count", cnt_a, 3'd0);

        rxd_a = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        check("brk_count_low", cnt_a, 3'd1);
        check("brk_busy_low", busy_a, 1'b1);
        rxd_a = 1'b1;
        repeat (6) @(negedge clk);
        check("brk_busy_rel", busy_a, 1'b0);
        check("brk_count", cnt_a, 3'd1);
        check("brk_data", data_a, 8'h00);
        check("brk_errs", {perr_a, ferr_a}, 2'b01);
        pop_a();
        send_frame(0, 8'h5A, 1'b0, 1'b0);
        check("post_brk_data", data_a, 8'h5A);
        check("post_brk_ferr", ferr_a, 1'b0);
        check("post_brk_count", cnt_a, 3'd1);
        pop_a();

        ov0 = ov_cnt;
        for (int i = 1; i <= 5; i++) begin
            send_frame(0, 8'(i), 1'b0, 1'b0);
            if (i == 4) check("ovr_none_yet", ov_cnt - ov0, 0);
        end
        repeat (4) @(negedge clk);
        check("ovr_count", cnt_a, 3'd4);
        check("ovr_pulses", ov_cnt - ov0, 1);
        for (int i = 1; i <= 4; i++) begin
            check("ovr_rd_valid", valid_a, 1'b1);
            check("ovr_rd_data", data_a, 8'(i));
            pop_a();
        end
        check("ovr_empty", valid_a, 1'b0);
        pop_a();
        check("ready_empty_count", cnt_a, 3'd0);

        send_frame(0, 8'h11, 1'b0, 1'b0);
        check("pre_rst_count", cnt_a, 3'd1);
        drive_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(0, 1'b1);
        rxd_a = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_outs", {data_a, perr_a, ferr_a, valid_a, ovr_a, busy_a}, 13'd0);
        check("mid_rst_count", cnt_a, 3'd0);
        rxd_a = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_idle", {valid_a, busy_a}, 2'b00);
        send_frame(0, 8'hC3, 1'b0, 1'b0);
        check("post_rst_data", data_a, 8'hC3);
        check("post_rst_count", cnt_a, 3'd1);
        check("post_rst_errs", {perr_a, ferr_a}, 2'b00);
        check("b_quiet", {ovr_b, busy_b, cnt_b}, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
